// File: rtl/wb_arb_pkg.sv
// Shared state type, parameter defaults and legal parameter ranges for the
// N-master Wishbone RAM arbiter and its helpers.
package wb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_N_MST   = 2;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_QUOTA   = 4;
  localparam int DEF_TIMEOUT = 255;

  localparam int MIN_N_MST = 2;
  localparam int MAX_N_MST = 8;
  localparam int MIN_QUOTA = 1;
  localparam int MAX_QUOTA = 15;

  // A disabled timeout (0) still needs a one-bit counter to keep widths legal.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: returns the first asserted request at or after
// ptr, wrapping from N-1 back to 0.
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx   = IW'((int'(ptr) + k) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter_n.sv
// N-master Wishbone arbiter in front of a single RAM port: rotating priority,
// a per-grant beat quota and a stall timeout that aborts a hung transfer.
module wb_ram_arbiter_n
  import wb_arb_pkg::*;
#(
  parameter int N_MST   = DEF_N_MST,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int QUOTA   = DEF_QUOTA,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [N_MST-1:0]        m_stb_i,
  input  logic [N_MST-1:0]        m_cyc_i,
  input  logic [N_MST-1:0]        m_we_i,
  input  logic [N_MST*(DW/8)-1:0] m_sel_i,
  input  logic [N_MST*AW-1:0]     m_adr_i,
  input  logic [N_MST*DW-1:0]     m_dat_i,
  output logic [N_MST-1:0]        m_ack_o,
  output logic [N_MST-1:0]        m_err_o,
  output logic [N_MST*DW-1:0]     m_dat_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  output logic                    s_we_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  input  logic                    s_ack_i,
  input  logic [DW-1:0]           s_dat_i,
  output logic [N_MST-1:0]        grant_o,
  output logic                    timeout_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(N_MST);
  localparam int BW = cnt_width(QUOTA);
  localparam int TW = cnt_width(TIMEOUT);

  if (N_MST < MIN_N_MST || N_MST > MAX_N_MST || QUOTA < MIN_QUOTA || QUOTA > MAX_QUOTA) begin : g_bad_param
    $error("wb_ram_arbiter_n: N_MST or QUOTA outside legal range");
  end

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    owner_q, rr_ptr_q, pick_idx;
  logic             pick_valid;
  logic [N_MST-1:0] req;
  logic [BW-1:0]    beat_q;
  logic [TW-1:0]    to_q;
  logic             in_grant, owner_cyc, owner_stb;
  logic             timeout_fire, quota_done, release_grant;

  assign req = m_cyc_i & m_stb_i;

  rr_priority_pick #(.N(N_MST), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign in_grant  = (state_q == GRANT);
  assign owner_cyc = m_cyc_i[owner_q];
  assign owner_stb = m_stb_i[owner_q];

  // An ack in the expiry cycle wins, so the RAM must not ack combinationally from s_stb_o.
  assign timeout_fire  = (TIMEOUT != 0) && in_grant && owner_cyc && owner_stb && !s_ack_i
                         && (to_q == TW'(TIMEOUT - 1));
  assign quota_done    = in_grant && s_ack_i && (beat_q == BW'(QUOTA - 1));
  assign release_grant = timeout_fire || quota_done || (in_grant && !owner_cyc);

  always_comb begin
    state_d   = state_q;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_dat_o   = '0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = GRANT;
      end
      GRANT: begin
        if (release_grant) state_d = IDLE;
        s_stb_o = owner_stb && !timeout_fire;
        s_cyc_o = owner_cyc && !timeout_fire;
        s_we_o  = m_we_i[owner_q];
        s_sel_o = m_sel_i[int'(owner_q)*SW +: SW];
        s_adr_o = m_adr_i[int'(owner_q)*AW +: AW];
        s_dat_o = m_dat_i[int'(owner_q)*DW +: DW];
        m_ack_o[owner_q] = s_ack_i;
        m_err_o[owner_q] = timeout_fire;
        m_dat_o[int'(owner_q)*DW +: DW] = s_dat_i;
        timeout_o = timeout_fire;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters restart on every new grant; both saturate rather than wrap.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_o  <= '0;
      beat_q   <= '0;
      to_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (pick_valid) begin
          owner_q <= pick_idx;
          grant_o <= N_MST'(1) << pick_idx;
          beat_q  <= '0;
          to_q    <= '0;
        end
      end else if (release_grant) begin
        grant_o  <= '0;
        rr_ptr_q <= (owner_q == IW'(N_MST - 1)) ? '0 : owner_q + 1'b1;
      end else if (s_ack_i) begin
        if (beat_q != BW'(QUOTA)) beat_q <= beat_q + 1'b1;
        to_q <= '0;
      end else if (owner_cyc && owner_stb && (to_q != TW'(TIMEOUT))) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter_n.sv
// Self-checking bench: a 2-master arbiter driven from a cycle vector table and
// a 4-master arbiter driven by hand-written multi-cycle sequences.
module tb_wb_ram_arbiter_n;

  localparam logic [31:0] RAM_DAT = 32'hDEAD_BEEF;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 wb_clk = ~wb_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 2-master instance
  logic [1:0]  a_stb = '0, a_cyc = '0;
  logic [1:0]  a_we = 2'b10;
  logic [7:0]  a_sel = {4'hC, 4'h3};
  logic [63:0] a_adr = {32'h0000_0101, 32'h0000_0100};
  logic [63:0] a_mdat = {32'hA000_0001, 32'hA000_0000};
  logic [1:0]  a_ack_o, a_err_o, a_grant;
  logic [63:0] a_dat_o;
  logic        a_sstb, a_scyc, a_swe, a_to;
  logic [3:0]  a_ssel;
  logic [31:0] a_sadr, a_sdat;
  logic        a_sack = 1'b0;

  wb_ram_arbiter_n #(.N_MST(2), .AW(32), .DW(32), .QUOTA(4), .TIMEOUT(8)) dut2 (
    .wb_clk_i(wb_clk), .wb_rst_i(wb_rst),
    .m_stb_i(a_stb), .m_cyc_i(a_cyc), .m_we_i(a_we), .m_sel_i(a_sel),
    .m_adr_i(a_adr), .m_dat_i(a_mdat), .m_ack_o(a_ack_o), .m_err_o(a_err_o),
    .m_dat_o(a_dat_o), .s_stb_o(a_sstb), .s_cyc_o(a_scyc), .s_we_o(a_swe),
    .s_sel_o(a_ssel), .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_ack_i(a_sack),
    .s_dat_i(RAM_DAT), .grant_o(a_grant), .timeout_o(a_to)
  );

  // 4-master instance
  logic [3:0]   b_stb = '0, b_cyc = '0, b_we = '0;
  logic [15:0]  b_sel = 16'hFFFF;
  logic [127:0] b_adr = {32'h203, 32'h202, 32'h201, 32'h200};
  logic [127:0] b_mdat = '0;
  logic [3:0]   b_ack_o, b_err_o, b_grant;
  logic [127:0] b_dat_o;
  logic         b_sstb, b_scyc, b_swe, b_to;
  logic [3:0]   b_ssel;
  logic [31:0]  b_sadr, b_sdat;
  logic         b_sack = 1'b0;

  wb_ram_arbiter_n #(.N_MST(4), .AW(32), .DW(32), .QUOTA(4), .TIMEOUT(8)) dut4 (
    .wb_clk_i(wb_clk), .wb_rst_i(wb_rst),
    .m_stb_i(b_stb), .m_cyc_i(b_cyc), .m_we_i(b_we), .m_sel_i(b_sel),
    .m_adr_i(b_adr), .m_dat_i(b_mdat), .m_ack_o(b_ack_o), .m_err_o(b_err_o),
    .m_dat_o(b_dat_o), .s_stb_o(b_sstb), .s_cyc_o(b_scyc), .s_we_o(b_swe),
    .s_sel_o(b_ssel), .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_ack_i(b_sack),
    .s_dat_i(RAM_DAT), .grant_o(b_grant), .timeout_o(b_to)
  );

  typedef struct {
    logic [1:0] stb, cyc;
    logic       ack;
    logic [1:0] e_grant;
    logic       e_stb, e_cyc;
    logic [1:0] e_ack, e_err;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [1:0] stb, input logic [1:0] cyc, input logic ack,
                        input logic [1:0] eg, input logic es, input logic ec,
                        input logic [1:0] ea, input logic [1:0] ee, input logic et);
    vec_t v;
    v.stb = stb; v.cyc = cyc; v.ack = ack; v.e_grant = eg; v.e_stb = es;
    v.e_cyc = ec; v.e_ack = ea; v.e_err = ee; v.e_to = et;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge wb_clk);
    a_stb = v.stb; a_cyc = v.cyc; a_sack = v.ack;
    #1;
  endtask

  task automatic checkVector(input int k, input vec_t v);
    logic [31:0] e_adr, e_sdat;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [63:0] e_mdat;
    e_adr = '0; e_sdat = '0; e_sel = '0; e_we = 1'b0; e_mdat = '0;
    if (v.e_grant[0]) begin
      e_adr = 32'h100; e_sel = 4'h3; e_we = 1'b0; e_sdat = 32'hA000_0000; e_mdat = {32'h0, RAM_DAT};
    end
    if (v.e_grant[1]) begin
      e_adr = 32'h101; e_sel = 4'hC; e_we = 1'b1; e_sdat = 32'hA000_0001; e_mdat = {RAM_DAT, 32'h0};
    end
    checkOutput($sformatf("v%0d grant", k), a_grant, v.e_grant);
    checkOutput($sformatf("v%0d s_stb", k), a_sstb, v.e_stb);
    checkOutput($sformatf("v%0d s_cyc", k), a_scyc, v.e_cyc);
    checkOutput($sformatf("v%0d m_ack", k), a_ack_o, v.e_ack);
    checkOutput($sformatf("v%0d m_err", k), a_err_o, v.e_err);
    checkOutput($sformatf("v%0d timeout", k), a_to, v.e_to);
    checkOutput($sformatf("v%0d s_adr", k), a_sadr, e_adr);
    checkOutput($sformatf("v%0d s_sel", k), a_ssel, e_sel);
    checkOutput($sformatf("v%0d s_we", k), a_swe, e_we);
    checkOutput($sformatf("v%0d s_dat", k), a_sdat, e_sdat);
    checkOutput($sformatf("v%0d m_dat", k), a_dat_o, e_mdat);
  endtask

  task automatic applyStimulus4(input logic [3:0] stb, input logic [3:0] cyc, input logic ack);
    @(negedge wb_clk);
    b_stb = stb; b_cyc = cyc; b_sack = ack;
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] eg, input logic es, input logic ec,
                        input logic [3:0] ea, input logic [3:0] ee);
    checkOutput({tag, " grant"}, b_grant, eg);
    checkOutput({tag, " s_stb"}, b_sstb, es);
    checkOutput({tag, " s_cyc"}, b_scyc, ec);
    checkOutput({tag, " m_ack"}, b_ack_o, ea);
    checkOutput({tag, " m_err"}, b_err_o, ee);
    checkOutput({tag, " timeout"}, b_to, |ee);
  endtask

  initial begin
    // Two-master table: quota handoff, ack on cyc drop, lone regrant, timeout, ack-beats-timeout
    addVec(2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 4; i++) addVec(2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    addVec(2'b11, 2'b11, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b11, 2'b11, 0, 2'b10, 1, 1, 2'b00, 2'b00, 0);
    addVec(2'b01, 2'b01, 1, 2'b10, 0, 0, 2'b10, 2'b00, 0);
    addVec(2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    addVec(2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    addVec(2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 7; i++) addVec(2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00, 0);
    addVec(2'b10, 2'b10, 0, 2'b10, 0, 0, 2'b00, 2'b10, 1);
    addVec(2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 7; i++) addVec(2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 2'b00, 0);
    addVec(2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    addVec(2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0);
    addVec(2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);

    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    #1;
    checkOutput("reset grant2", a_grant, 2'b00);
    checkOutput("reset s_cyc2", a_scyc, 1'b0);
    checkOutput("reset grant4", b_grant, 4'b0000);
    checkOutput("reset s_cyc4", b_scyc, 1'b0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkVector(k, vecs[k]);
    end

    // Walk rr_ptr to 2 by granting and releasing master1
    applyStimulus4(4'b0010, 4'b0010, 0); check4("p2 idle", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b0000, 4'b0000, 0); check4("p2 drop", 4'b0010, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b1010, 4'b1010, 0); check4("rr idle", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b1010, 4'b1010, 0); check4("rr m3 first", 4'b1000, 1, 1, 4'b0000, 4'b0000);
    checkOutput("rr m3 adr", b_sadr, 32'h203);
    applyStimulus4(4'b0010, 4'b0010, 0); check4("m3 drop", 4'b1000, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b0010, 4'b0010, 0); check4("rr idle2", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b1010, 4'b1010, 1); check4("rr m1 next", 4'b0010, 1, 1, 4'b0010, 4'b0000);
    checkOutput("m1 rdata", b_dat_o, {64'h0, RAM_DAT, 32'h0});

    // Bus lock: master1 keeps cyc with stb low between beats while master3 waits
    for (int b = 2; b <= 4; b++) begin
      for (int c = 0; c < 3; c++) begin
        applyStimulus4(4'b1000, 4'b1010, 0);
        check4($sformatf("lock b%0d c%0d", b, c), 4'b0010, 0, 1, 4'b0000, 4'b0000);
      end
      applyStimulus4(4'b1010, 4'b1010, 1);
      check4($sformatf("beat %0d", b), 4'b0010, 1, 1, 4'b0010, 4'b0000);
    end
    applyStimulus4(4'b1010, 4'b1010, 0); check4("quota idle", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b1010, 4'b1010, 0); check4("quota m3", 4'b1000, 1, 1, 4'b0000, 4'b0000);

    // Stall 7 stb-high cycles split by 5 stb-low cycles: no timeout may fire
    for (int i = 0; i < 4; i++) begin
      applyStimulus4(4'b1010, 4'b1010, 0); check4($sformatf("stall a%0d", i), 4'b1000, 1, 1, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus4(4'b0010, 4'b1010, 0); check4($sformatf("hold %0d", i), 4'b1000, 0, 1, 4'b0000, 4'b0000);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus4(4'b1010, 4'b1010, 0); check4($sformatf("stall b%0d", i), 4'b1000, 1, 1, 4'b0000, 4'b0000);
    end
    applyStimulus4(4'b1010, 4'b1010, 1); check4("late ack", 4'b1000, 1, 1, 4'b1000, 4'b0000);
    applyStimulus4(4'b1111, 4'b1111, 0); check4("pre reset", 4'b1000, 1, 1, 4'b0000, 4'b0000);

    // Reset mid-grant with the RAM acking: transfer aborted silently
    @(negedge wb_clk);
    b_sack = 1'b1;
    wb_rst = 1'b1;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    #1;
    check4("reset abort", 4'b0000, 0, 0, 4'b0000, 4'b0000);
    applyStimulus4(4'b1111, 4'b1111, 0); check4("post reset m0", 4'b0001, 1, 1, 4'b0000, 4'b0000);
    applyStimulus4(4'b0000, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
